gpio_irq: RTL and testbench
===========================

GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 Parameter NUM_PINS, default 8: pin count; SHALL be 8, 16, 24 or 32. NUM_BANKS = NUM_PINS/8.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth; SHALL be 2..4.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_addr  input  6  register select; [5:2] = register index, [1:0] = bank (pins 8*bank..8*bank+7).
REQ-006 i_data  input  8  write data.
REQ-007 i_rw  input  1  1 = read, 0 = write.
REQ-008 i_en  input  1  bus access qualifier, one cycle per access.
REQ-009 o_data  output  8  registered read data.
REQ-010 i_pins  input  NUM_PINS  asynchronous pin inputs.
REQ-011 o_pins  output  NUM_PINS  pin output values, equal to OUT register.
REQ-012 o_pins_oe  output  NUM_PINS  pin output enables, equal to OE register.
REQ-013 o_irq  output  1  registered level interrupt, active-high.

Function
REQ-014 Register map (index: name): 0 OE (RW), 1 OUT (RW), 2 OUT_SET (W, reads 0), 3 OUT_CLR (W, reads 0), 4 IN (R), 5 IRQ_EN (RW), 6 RISE_EN (RW), 7 FALL_EN (RW), 8 STATUS (R/W1C), 9 PENDING (R, STATUS & IRQ_EN); indices 10-15 read 0, writes ignored.
REQ-015 Write: on rising i_clk with i_en=1, i_rw=0, selected bank byte updated; visible next cycle.
REQ-016 OUT_SET write: OUT |= i_data; OUT_CLR write: OUT &= ~i_data; other bits unchanged.
REQ-017 Read: on rising i_clk with i_en=1, i_rw=1, o_data loaded with selected byte (1-cycle latency); o_data holds otherwise.
REQ-018 Bank >= NUM_BANKS: reads return 8'h00; writes ignored.
REQ-019 Each i_pins bit passes through SYNC_STAGES flops; IN returns synchroniser output.
REQ-020 Edge detector: prev register holds previous synchronised value; rise = sync & ~prev, fall = ~sync & prev.
REQ-021 STATUS[i] set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); both enables set = either edge; IRQ_EN does not gate setting.
REQ-022 STATUS write: bits with i_data=1 cleared, 0 bits unchanged; same-cycle set and W1C on one bit: set wins.
REQ-023 Reads never modify STATUS.
REQ-024 o_irq <= |(STATUS & IRQ_EN), updated every cycle; deasserts one cycle after last pending bit cleared or disabled.
REQ-025 Pin edge to STATUS bit set latency: SYNC_STAGES+1 cycles; to o_irq: SYNC_STAGES+2 cycles.
REQ-026 Arm counter: after reset release, edge detection suppressed for SYNC_STAGES+1 cycles, then permanently armed; prevents spurious edges from reset values.
REQ-027 Pulse shorter than one i_clk period: capture not guaranteed; pulses >= 2 cycles wide SHALL set STATUS.

Reset
REQ-028 While i_reset_n=0: OE, OUT, IRQ_EN, RISE_EN, FALL_EN, STATUS, synchroniser, prev, arm counter, o_data, o_irq all 0; o_pins=0, o_pins_oe=0.
REQ-029 Reset asserted mid-access or mid-edge aborts it; no state survives; first post-reset access behaves per REQ-015/017.

Verification
REQ-030 Reset with i_pins all 1, RISE_EN=8'hFF after arm -> STATUS stays 0 (no spurious edge); IN reads 8'hFF.
REQ-031 NUM_PINS=16: write OUT bank1=8'hA5, OUT_SET bank1=8'h0A, OUT_CLR bank1=8'h80 -> o_pins[15:8]=8'h2F, o_pins[7:0]=0; read OUT bank1 -> 8'h2F one cycle after access.
REQ-032 RISE_EN=8'h01, IRQ_EN=8'h01, i_pins[0] 0->1 at cycle T -> STATUS=8'h01 at T+3, o_irq=1 at T+4 (SYNC_STAGES=2); write STATUS 8'h01 -> o_irq=0 two cycles later.
REQ-033 FALL_EN=RISE_EN=8'h04, W1C of bit2 coincident with new edge on pin2 -> STATUS bit2 remains 1.
REQ-034 IRQ_EN=0, edge on pin3 with RISE_EN[3]=1 -> STATUS=8'h08, PENDING=0, o_irq=0; then IRQ_EN=8'h08 -> o_irq=1 next cycle.
REQ-035 NUM_PINS=8: read bank 2 and index 12 -> 8'h00; write bank 3 -> no register change.

Source files
------------

// File: rtl/gpio_irq_if.sv
// Register bus between a host and the GPIO interrupt block.
// One-cycle accesses qualified by i_en; read data returns on o_data one cycle later.
interface gpio_irq_if;
    logic [5:0] i_addr;
    logic [7:0] i_data;
    logic       i_rw;
    logic       i_en;
    logic [7:0] o_data;

    modport master (
        output i_addr,
        output i_data,
        output i_rw,
        output i_en,
        input  o_data
    );

    modport slave (
        input  i_addr,
        input  i_data,
        input  i_rw,
        input  i_en,
        output o_data
    );
endinterface

// File: rtl/gpio_irq.sv
// GPIO block with byte-banked registers, input synchronisers, per-pin edge
// detection into a W1C status register and a registered level interrupt.
module gpio_irq #(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    gpio_irq_if.slave           bus,
    input  logic [NUM_PINS-1:0] i_pins,
    output logic [NUM_PINS-1:0] o_pins,
    output logic [NUM_PINS-1:0] o_pins_oe,
    output logic                o_irq
);

    localparam int NUM_BANKS = NUM_PINS / 8;
    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

    localparam logic [3:0] IDX_OE      = 4'd0;
    localparam logic [3:0] IDX_OUT     = 4'd1;
    localparam logic [3:0] IDX_OUT_SET = 4'd2;
    localparam logic [3:0] IDX_OUT_CLR = 4'd3;
    localparam logic [3:0] IDX_IN      = 4'd4;
    localparam logic [3:0] IDX_IRQ_EN  = 4'd5;
    localparam logic [3:0] IDX_RISE_EN = 4'd6;
    localparam logic [3:0] IDX_FALL_EN = 4'd7;
    localparam logic [3:0] IDX_STATUS  = 4'd8;
    localparam logic [3:0] IDX_PENDING = 4'd9;

    logic [NUM_PINS-1:0] oe_q;
    logic [NUM_PINS-1:0] out_q;
    logic [NUM_PINS-1:0] irq_en_q;
    logic [NUM_PINS-1:0] rise_en_q;
    logic [NUM_PINS-1:0] fall_en_q;
    logic [NUM_PINS-1:0] status_q;
    logic [NUM_PINS-1:0] prev_q;
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
    logic [2:0]          arm_cnt_q;

    logic [3:0]          reg_idx;
    logic [1:0]          bank_sel;
    logic                bank_ok;
    logic                wr_en;
    logic                rd_en;
    logic [NUM_PINS-1:0] byte_mask;
    logic [NUM_PINS-1:0] wdata_rep;
    logic [NUM_PINS-1:0] wr_bits;
    logic [NUM_PINS-1:0] sync_out;
    logic [NUM_PINS-1:0] rise;
    logic [NUM_PINS-1:0] fall;
    logic [NUM_PINS-1:0] set_mask;
    logic [NUM_PINS-1:0] w1c_mask;
    logic [NUM_PINS-1:0] status_nxt;
    logic [NUM_PINS-1:0] rd_vec;
    logic [7:0]          rd_byte;
    logic                armed;

    assign reg_idx   = bus.i_addr[5:2];
    assign bank_sel  = bus.i_addr[1:0];
    assign bank_ok   = int'(bank_sel) < NUM_BANKS;
    assign wr_en     = bus.i_en && !bus.i_rw && bank_ok;
    assign rd_en     = bus.i_en && bus.i_rw;
    assign wdata_rep = {NUM_BANKS{bus.i_data}};
    assign wr_bits   = wdata_rep & byte_mask;

    always_comb begin
        byte_mask = '0;
        if (bank_ok) begin
            byte_mask = NUM_PINS'(8'hFF) << {bank_sel, 3'b000};
        end
    end

    // Edge detection stays off until the synchroniser has flushed its reset zeros.
    assign armed    = (arm_cnt_q == ARM_LAST);
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;
    assign set_mask = armed ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
    assign w1c_mask = (wr_en && reg_idx == IDX_STATUS) ? wr_bits : '0;

    // A set in the same cycle as a W1C on that bit wins, so no edge is lost.
    assign status_nxt = (status_q & ~w1c_mask) | set_mask;

    always_comb begin
        rd_vec = '0;
        case (reg_idx)
            IDX_OE:      rd_vec = oe_q;
            IDX_OUT:     rd_vec = out_q;
            IDX_IN:      rd_vec = sync_out;
            IDX_IRQ_EN:  rd_vec = irq_en_q;
            IDX_RISE_EN: rd_vec = rise_en_q;
            IDX_FALL_EN: rd_vec = fall_en_q;
            IDX_STATUS:  rd_vec = status_q;
            IDX_PENDING: rd_vec = status_q & irq_en_q;
            default:     rd_vec = '0;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        if (bank_ok) begin
            rd_byte = 8'(rd_vec >> {bank_sel, 3'b000});
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q    <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pins};
            prev_q <= sync_out;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            oe_q      <= '0;
            out_q     <= '0;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr_en) begin
            case (reg_idx)
                IDX_OE:      oe_q      <= (oe_q & ~byte_mask) | wr_bits;
                IDX_OUT:     out_q     <= (out_q & ~byte_mask) | wr_bits;
                IDX_OUT_SET: out_q     <= out_q | wr_bits;
                IDX_OUT_CLR: out_q     <= out_q & ~wr_bits;
                IDX_IRQ_EN:  irq_en_q  <= (irq_en_q & ~byte_mask) | wr_bits;
                IDX_RISE_EN: rise_en_q <= (rise_en_q & ~byte_mask) | wr_bits;
                IDX_FALL_EN: fall_en_q <= (fall_en_q & ~byte_mask) | wr_bits;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            status_q   <= '0;
            o_irq      <= 1'b0;
            bus.o_data <= 8'h00;
        end else begin
            status_q <= status_nxt;
            o_irq    <= |(status_q & irq_en_q);
            if (rd_en) begin
                bus.o_data <= rd_byte;
            end
        end
    end

    assign o_pins    = out_q;
    assign o_pins_oe = oe_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq (16 pins, 2-stage sync): register vector table plus
// hand-written edge/interrupt timing sequences; read data checked via a queue.
module tb_gpio_irq;

    localparam int NP = 16;

    localparam logic [3:0] R_OE = 4'd0, R_OUT = 4'd1, R_SET = 4'd2, R_CLR = 4'd3;
    localparam logic [3:0] R_IN = 4'd4, R_IRQEN = 4'd5, R_RISE = 4'd6, R_FALL = 4'd7;
    localparam logic [3:0] R_STAT = 4'd8, R_PEND = 4'd9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] pins = '0;
    logic [NP-1:0] o_pins;
    logic [NP-1:0] o_oe;
    logic          irq;

    gpio_irq_if bus_if ();

    gpio_irq #(.NUM_PINS(NP), .SYNC_STAGES(2)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_if),
        .i_pins    (pins),
        .o_pins    (o_pins),
        .o_pins_oe (o_oe),
        .o_irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    bit         rd_issued = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: a read accepted at a rising edge is compared at the next falling edge.
    always @(posedge clk) rd_issued <= bus_if.i_en && bus_if.i_rw && rst_n;

    always @(negedge clk) begin
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check(name_q.pop_front(), {24'h0, bus_if.o_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic bus_write(input logic [3:0] idx, input logic [1:0] bank, input logic [7:0] data);
        bus_if.i_addr = {idx, bank};
        bus_if.i_data = data;
        bus_if.i_rw   = 1'b0;
        bus_if.i_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.i_en = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] idx, input logic [1:0] bank, input logic [7:0] exp,
                            input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        bus_if.i_addr = {idx, bank};
        bus_if.i_data = 8'h00;
        bus_if.i_rw   = 1'b1;
        bus_if.i_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.i_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        bit         rd;
        logic [3:0] idx;
        logic [1:0] bank;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, R_OE,   2'd0, 8'h5A};
        vecs[1]  = '{1'b0, R_OE,   2'd1, 8'hC3};
        vecs[2]  = '{1'b1, R_OE,   2'd0, 8'h5A};
        vecs[3]  = '{1'b0, R_OUT,  2'd1, 8'hA5};
        vecs[4]  = '{1'b0, R_SET,  2'd1, 8'h0A};
        vecs[5]  = '{1'b0, R_CLR,  2'd1, 8'h80};
        vecs[6]  = '{1'b1, R_OUT,  2'd1, 8'h2F};
        vecs[7]  = '{1'b1, R_OUT,  2'd0, 8'h00};
        vecs[8]  = '{1'b1, R_SET,  2'd1, 8'h00};
        vecs[9]  = '{1'b1, R_CLR,  2'd1, 8'h00};
        vecs[10] = '{1'b0, R_OE,   2'd2, 8'hFF};
        vecs[11] = '{1'b0, R_OUT,  2'd3, 8'hFF};
        vecs[12] = '{1'b1, R_OE,   2'd2, 8'h00};
        vecs[13] = '{1'b1, 4'd12,  2'd0, 8'h00};
        vecs[14] = '{1'b0, 4'd10,  2'd0, 8'hFF};
        vecs[15] = '{1'b1, 4'd10,  2'd0, 8'h00};
        vecs[16] = '{1'b1, R_OE,   2'd1, 8'hC3};

        bus_if.i_addr = '0;
        bus_if.i_data = '0;
        bus_if.i_rw   = 1'b0;
        bus_if.i_en   = 1'b0;

        // Reset with all pins high; rising edges enabled straight after release.
        pins = '1;
        idle(3);
        check("rst_pins",  {16'h0, o_pins}, 32'h0);
        check("rst_oe",    {16'h0, o_oe},   32'h0);
        check("rst_irq",   {31'h0, irq},    32'h0);
        check("rst_odata", {24'h0, bus_if.o_data}, 32'h0);
        rst_n = 1'b1;
        bus_write(R_RISE, 2'd0, 8'hFF);
        bus_write(R_RISE, 2'd1, 8'hFF);
        idle(4);
        bus_read(R_STAT, 2'd0, 8'h00, "arm_status_b0");
        bus_read(R_STAT, 2'd1, 8'h00, "arm_status_b1");
        bus_read(R_IN,   2'd0, 8'hFF, "in_b0");
        bus_read(R_IN,   2'd1, 8'hFF, "in_b1");
        check("arm_irq", {31'h0, irq}, 32'h0);

        rst_n = 1'b0;
        pins  = '0;
        idle(2);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rd) bus_read(vecs[i].idx, vecs[i].bank, vecs[i].data, $sformatf("vec%0d", i));
            else            bus_write(vecs[i].idx, vecs[i].bank, vecs[i].data);
        end
        check("vec_pins", {16'h0, o_pins}, 32'h2F00);
        check("vec_oe",   {16'h0, o_oe},   32'hC35A);
        bus_write(R_OE, 2'd0, 8'h5A);
        idle(1);
        check("rdata_hold", {24'h0, bus_if.o_data}, 32'hC3);

        // Rise on pin0: STATUS at T+3, irq at T+4; W1C drops irq one cycle late.
        bus_write(R_RISE,  2'd0, 8'h01);
        bus_write(R_IRQEN, 2'd0, 8'h01);
        idle(2);
        pins[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus_read(R_STAT, 2'd0, (k == 4) ? 8'h01 : 8'h00, $sformatf("lat_status_t%0d", k));
            check($sformatf("lat_irq_t%0d", k), {31'h0, irq}, (k == 4) ? 32'h1 : 32'h0);
        end
        bus_write(R_STAT, 2'd0, 8'h01);
        check("w1c_irq_hold", {31'h0, irq}, 32'h1);
        idle(1);
        check("w1c_irq_drop", {31'h0, irq}, 32'h0);

        // Both edges on pin2; W1C lands on the same edge that sets the bit.
        bus_write(R_RISE, 2'd0, 8'h04);
        bus_write(R_FALL, 2'd0, 8'h04);
        pins[2] = 1'b1;
        idle(4);
        bus_read(R_STAT, 2'd0, 8'h04, "either_rise");
        pins[2] = 1'b0;
        idle(2);
        bus_write(R_STAT, 2'd0, 8'h04);
        bus_read(R_STAT, 2'd0, 8'h04, "set_wins");
        bus_write(R_STAT, 2'd0, 8'h04);
        bus_read(R_STAT, 2'd0, 8'h00, "w1c_clear");
        check("pin2_irq", {31'h0, irq}, 32'h0);

        // STATUS sets without IRQ_EN; enabling later raises irq next cycle.
        bus_write(R_IRQEN, 2'd0, 8'h00);
        bus_write(R_RISE,  2'd0, 8'h08);
        pins[3] = 1'b1;
        idle(5);
        bus_read(R_STAT, 2'd0, 8'h08, "masked_status");
        bus_read(R_PEND, 2'd0, 8'h00, "masked_pending");
        check("masked_irq", {31'h0, irq}, 32'h0);
        bus_write(R_IRQEN, 2'd0, 8'h08);
        check("en_irq_t0", {31'h0, irq}, 32'h0);
        idle(1);
        check("en_irq_t1", {31'h0, irq}, 32'h1);
        bus_read(R_PEND, 2'd0, 8'h08, "en_pending");

        // Two-cycle pulse on pin9 with falling edge enabled only.
        bus_write(R_FALL, 2'd1, 8'h02);
        pins[9] = 1'b1;
        idle(2);
        pins[9] = 1'b0;
        idle(5);
        bus_read(R_STAT, 2'd1, 8'h02, "pulse_b1");

        // Reset asserted in the middle of a write aborts it.
        bus_if.i_addr = {R_OE, 2'd0};
        bus_if.i_data = 8'hFF;
        bus_if.i_rw   = 1'b0;
        bus_if.i_en   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_oe",  {16'h0, o_oe}, 32'h0);
        check("midrst_irq", {31'h0, irq},  32'h0);
        bus_if.i_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        bus_read(R_OE,   2'd0, 8'h00, "post_rst_oe");
        bus_read(R_STAT, 2'd1, 8'h00, "post_rst_status");
        bus_write(R_OE, 2'd0, 8'h3C);
        bus_read(R_OE,  2'd0, 8'h3C, "post_rst_access");

        idle(2);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
